control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/microcode_rom.sv | 54 +++++
 rtl/control_sequencer.sv | 56 +++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, control-word bit positions and microstep count.
// Imported by the sequencer, the microcode ROM and the datapath blocks.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam int unsigned CTRL_W = 16;

    localparam int unsigned HLT = 15;
    localparam int unsigned MI  = 14;
    localparam int unsigned RI  = 13;
    localparam int unsigned RO  = 12;
    localparam int unsigned IO  = 11;
    localparam int unsigned II  = 10;
    localparam int unsigned AI  = 9;
    localparam int unsigned AO  = 8;
    localparam int unsigned EO  = 7;
    localparam int unsigned SU  = 6;
    localparam int unsigned BI  = 5;
    localparam int unsigned OI  = 4;
    localparam int unsigned CE  = 3;
    localparam int unsigned CO  = 2;
    localparam int unsigned J   = 1;
    localparam int unsigned FI  = 0;

    localparam int unsigned STEP_COUNT = 5;
    localparam int unsigned STEP_W     = 3;

    function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
        return CTRL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Purely combinational microcode table: (step, opcode, flags, halted) -> control word.
// Flags only matter at T2 of JC/JZ; a halted machine asserts HLT alone.
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    input  logic [3:0]        opcode,
    input  logic              flag_carry,
    input  logic              flag_zero,
    input  logic              halted,
    output logic [CTRL_W-1:0] ctrl
);

    always_comb begin
        ctrl = '0;
        if (halted) begin
            ctrl = cbit(HLT);
        end else begin
            case (step)
                3'd0: ctrl = cbit(CO) | cbit(MI);
                3'd1: ctrl = cbit(RO) | cbit(II) | cbit(CE);
                3'd2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = cbit(IO) | cbit(MI);
                        OP_LDI: ctrl = cbit(IO) | cbit(AI);
                        OP_JMP: ctrl = cbit(IO) | cbit(J);
                        OP_JC:  ctrl = flag_carry ? (cbit(IO) | cbit(J)) : '0;
                        OP_JZ:  ctrl = flag_zero  ? (cbit(IO) | cbit(J)) : '0;
                        OP_OUT: ctrl = cbit(AO) | cbit(OI);
                        OP_HLT: ctrl = cbit(HLT);
                        default: ctrl = '0;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA:         ctrl = cbit(RO) | cbit(AI);
                        OP_ADD, OP_SUB: ctrl = cbit(RO) | cbit(BI);
                        OP_STA:         ctrl = cbit(AO) | cbit(RI);
                        default:        ctrl = '0;
                    endcase
                end
                3'd4: begin
                    case (opcode)
                        OP_ADD:  ctrl = cbit(EO) | cbit(AI) | cbit(FI);
                        OP_SUB:  ctrl = cbit(EO) | cbit(AI) | cbit(SU) | cbit(FI);
                        default: ctrl = '0;
                    endcase
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer: five-step counter plus sticky halt flag; control word comes
// combinationally from microcode_rom so ctrl follows step with no extra latency.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        opcode,
    input  logic              flag_carry,
    input  logic              flag_zero,
    output logic [CTRL_W-1:0] ctrl,
    output logic [STEP_W-1:0] step,
    output logic              halted
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_COUNT - 1);
    localparam logic [STEP_W-1:0] STEP_HLT  = 3'd2;

    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d;

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            step_d = (step_q == STEP_LAST) ? '0 : step_q + 3'd1;
            // Step still advances on the halting edge, so it freezes at T3.
            if (step_q == STEP_HLT && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    microcode_rom u_rom (
        .step       (step_q),
        .opcode     (opcode),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .halted     (halted_q),
        .ctrl       (ctrl)
    );

    assign step   = step_q;
    assign halted = halted_q;

endmodule
